windowed_kofn_detector: RTL and testbench
=========================================

Name: windowed_kofn_detector

Overview:
- Sequential, parametrised successor to the 3-input pair/triple (2-of-3 majority) detector.
- Watches a serial bit stream through a sliding window of the last N accepted bits.
- Asserts out when at least thresh of those bits are 1.
- Keeps a saturating count of detection events (rising edges of out).
- Sits between a bit-serial source and control logic that needs a debounced or majority "enough ones recently" flag.

Parameters:
- N, 8: window depth in bits; legal range 2..32.
- CW, $clog2(N+1): width of count, thresh and fill, derived; must not be overridden.
- EW, 8: width of the saturating event counter.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- clear  input  1  synchronous clear of window, count, fill, out and events.
- in_val  input  1  in_bit is valid this cycle; the bit is shifted in.
- in_bit  input  1  serial data bit.
- thresh  input  CW  runtime threshold K; sampled combinationally every cycle.
- count  output  CW  number of 1s currently in the window (registered).
- full  output  1  window holds N accepted bits since reset/clear (registered).
- out  output  1  detection flag (registered).
- events  output  EW  saturating count of 0->1 transitions of out.

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately regardless of clk):
  - window = all 0; count = 0; fill = 0; full = 0; out = 0; events = 0.
  - Outputs stay there until the first rising edge with rst=1.
- Window:
  - N-bit shift register. On in_val=1: window <= {window[N-2:0], in_bit}; oldest = window[N-1] is discarded.
  - in_val=0: window, count and fill hold.
- Count:
  - Maintained incrementally: count_next = count + in_bit - oldest.
  - Must equal popcount(window) at all times; never exceeds N.
  - Oldest is 0 while not full because the window is zero-filled.
- Fill:
  - Internal CW-bit counter; increments on in_val while fill < N, then saturates at N.
  - full = (fill == N).
- Out: registered; out_next = full_next && (count_next >= thresh).
  - Latency: a bit accepted at edge t is reflected in count/full/out after edge t.
  - thresh is compared each cycle even when in_val=0, so out can change with thresh alone, one cycle later.
  - thresh = 0: out = full.
  - thresh > N: out stays 0.
- Events: increments when out_next=1 and out=0; saturates at 2^EW-1 with no wrap.
- Clear=1 at an edge:
  - Same effect as reset, synchronously.
  - Has priority over in_val in the same cycle; the bit offered that cycle is dropped.
- Reset asserted mid-stream: all state lost immediately; the window must refill N bits before out can assert.
- X-propagation: X on in_bit with in_val=1 may corrupt count/out (X out is acceptable). X on in_val must not be masked to 0.
- Equivalence: N=3 with thresh=2, once full, reproduces the 2-of-3 detector over the last three bits.

Test Plan:
- Reset then fill (N=8, thresh=5): reset, feed 8 ones with in_val=1 → count = 1..8, full rises after the 8th bit, out=1 only after the 8th edge, events=1.
- Sliding exit (N=8, thresh=5): after the above, feed 0s → count 7,6,5,4; out falls the cycle count becomes 4; events stays 1.
- Stall and runtime threshold: hold in_val=0 for 5 cycles → window and count unchanged; change thresh 5→3 while stalled → out rises one cycle later, events increments.
- Boundary thresholds (thresh=0 vs thresh=9, N=8):
  - thresh=0: out = full after 8 zero bits.
  - thresh=9: out never asserts even with all ones.
- Clear priority: clear=1 with in_val=1, in_bit=1 while full → next cycle count=0, full=0, out=0, events=0; the bit is not counted.
- Async reset mid-stream and saturation: drop rst between edges → all outputs 0 before the next edge. With EW=2, toggle out 5 times → events stops at 3.

Source files
------------

// File: rtl/windowed_kofn_detector.sv
// Sliding-window K-of-N ones detector: flags when at least thresh of the last N
// accepted bits are 1, and keeps a saturating count of flag rising edges.
module windowed_kofn_detector #(
  parameter int unsigned N  = 8,
  parameter int unsigned CW = $clog2(N + 1),
  parameter int unsigned EW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          in_val,
  input  logic          in_bit,
  input  logic [CW-1:0] thresh,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          out,
  output logic [EW-1:0] events
);

  localparam logic [CW-1:0] FILL_MAX   = CW'(N);
  localparam logic [EW-1:0] EVENTS_MAX = '1;

  logic [N-1:0]  window;
  logic [N-1:0]  window_next;
  logic [CW-1:0] fill;
  logic [CW-1:0] fill_next;
  logic [CW-1:0] count_next;
  logic          full_next;
  logic          out_next;
  logic [EW-1:0] events_next;
  logic          oldest;

  // Next-state: ternaries on in_val so an unknown in_val propagates instead of reading as 0.
  always_comb begin
    oldest      = window[N-1];
    window_next = in_val ? {window[N-2:0], in_bit} : window;
    count_next  = in_val ? CW'(count + CW'(in_bit) - CW'(oldest)) : count;
    fill_next   = (in_val && (fill != FILL_MAX)) ? CW'(fill + CW'(1)) : fill;
    full_next   = (fill_next == FILL_MAX);
    out_next    = full_next && (count_next >= thresh);
    events_next = (out_next && !out && (events != EVENTS_MAX)) ? EW'(events + EW'(1)) : events;
  end

  // State register; clear behaves as a synchronous reset and drops any offered bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      window <= '0;
      count  <= '0;
      fill   <= '0;
      full   <= 1'b0;
      out    <= 1'b0;
      events <= '0;
    end else if (clear) begin
      window <= '0;
      count  <= '0;
      fill   <= '0;
      full   <= 1'b0;
      out    <= 1'b0;
      events <= '0;
    end else begin
      window <= window_next;
      count  <= count_next;
      fill   <= fill_next;
      full   <= full_next;
      out    <= out_next;
      events <= events_next;
    end
  end

endmodule

// File: tb/tb_windowed_kofn_detector.sv
// Bench for windowed_kofn_detector: directed scenarios plus random traffic, checked
// every cycle against a queue-based model of the last N accepted bits.
module tb_windowed_kofn_detector;

  localparam int unsigned N  = 8;
  localparam int unsigned CW = $clog2(N + 1);

  logic          clk;
  logic          rst;
  logic          clear;
  logic          in_val;
  logic          in_bit;
  logic [CW-1:0] thresh;
  logic [CW-1:0] count_a, count_b;
  logic          full_a, full_b, out_a, out_b;
  logic [7:0]    events_a;
  logic [1:0]    events_b;

  int checks = 0;
  int errors = 0;

  windowed_kofn_detector #(.N(N), .EW(8)) u_dut (
    .clk(clk), .rst(rst), .clear(clear), .in_val(in_val), .in_bit(in_bit),
    .thresh(thresh), .count(count_a), .full(full_a), .out(out_a), .events(events_a)
  );

  windowed_kofn_detector #(.N(N), .EW(2)) u_sat (
    .clk(clk), .rst(rst), .clear(clear), .in_val(in_val), .in_bit(in_bit),
    .thresh(thresh), .count(count_b), .full(full_b), .out(out_b), .events(events_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: the accepted bits themselves, recounted from scratch every cycle.
  bit q[$];
  int m_count;
  bit m_full;
  bit m_out;
  int m_ev;

  always @(posedge clk or negedge rst) begin
    bit nxt;
    if (!rst || clear) begin
      q.delete();
      m_count = 0;
      m_full  = 1'b0;
      m_out   = 1'b0;
      m_ev    = 0;
    end else begin
      if (in_val) begin
        q.push_back(in_bit);
        if (q.size() > N) void'(q.pop_front());
      end
      m_count = 0;
      foreach (q[i]) m_count += int'(q[i]);
      m_full = (q.size() == N);
      nxt    = m_full && (m_count >= int'(thresh));
      if (nxt && !m_out) m_ev++;
      m_out = nxt;
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      check("cmp_count",    32'(count_a),  32'(m_count));
      check("cmp_full",     32'(full_a),   32'(m_full));
      check("cmp_out",      32'(out_a),    32'(m_out));
      check("cmp_events",   32'(events_a), 32'((m_ev > 255) ? 255 : m_ev));
      check("cmp_count_s",  32'(count_b),  32'(m_count));
      check("cmp_full_s",   32'(full_b),   32'(m_full));
      check("cmp_out_s",    32'(out_b),    32'(m_out));
      check("cmp_events_s", 32'(events_b), 32'((m_ev > 3) ? 3 : m_ev));
    end
  end

  task automatic drive(input logic v, input logic b);
    in_val = v;
    in_bit = b;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; clear = 1'b0; in_val = 1'b0; in_bit = 1'b0; thresh = CW'(5);
    repeat (2) @(negedge clk);
    check("reset_count",  32'(count_a),  32'd0);
    check("reset_full",   32'(full_a),   32'd0);
    check("reset_out",    32'(out_a),    32'd0);
    check("reset_events", 32'(events_a), 32'd0);
    #1 rst = 1'b1;

    // Fill with ones at thresh=5
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 1'b1);
      check("fill_count", 32'(count_a), 32'(i));
      check("fill_full",  32'(full_a),  32'(i == 8));
      check("fill_out",   32'(out_a),   32'(i == 8));
    end
    check("fill_events", 32'(events_a), 32'd1);

    // Slide zeros in
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0);
      check("slide_count", 32'(count_a), 32'(7 - i));
      check("slide_out",   32'(out_a),   32'(i < 3));
    end
    check("slide_events", 32'(events_a), 32'd1);

    // Stall, then lower threshold while stalled
    repeat (5) drive(1'b0, 1'b0);
    check("stall_count", 32'(count_a), 32'd4);
    check("stall_out",   32'(out_a),   32'd0);
    thresh = CW'(3);
    drive(1'b0, 1'b0);
    check("thresh_out",    32'(out_a),    32'd1);
    check("thresh_events", 32'(events_a), 32'd2);

    // Clear beats an offered 1
    clear = 1'b1;
    drive(1'b1, 1'b1);
    clear = 1'b0;
    check("clear_count",  32'(count_a),  32'd0);
    check("clear_full",   32'(full_a),   32'd0);
    check("clear_out",    32'(out_a),    32'd0);
    check("clear_events", 32'(events_a), 32'd0);

    // thresh=0 tracks full
    thresh = CW'(0);
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 1'b0);
      check("t0_out", 32'(out_a), 32'(i == 8));
    end
    check("t0_events", 32'(events_a), 32'd1);

    // thresh=9 never fires
    thresh = CW'(9);
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 1'b1);
      check("t9_out", 32'(out_a), 32'd0);
    end
    check("t9_count", 32'(count_a), 32'd8);

    // Five rising edges of out: 8-bit counter reaches 5, 2-bit counter sticks at 3
    clear = 1'b1;
    drive(1'b0, 1'b0);
    clear = 1'b0;
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      thresh = CW'(0);
      drive(1'b0, 1'b0);
      thresh = CW'(9);
      drive(1'b0, 1'b0);
    end
    check("sat_events_8", 32'(events_a), 32'd5);
    check("sat_events_2", 32'(events_b), 32'd3);

    // Asynchronous reset between edges
    #2 rst = 1'b0;
    #1;
    check("arst_count",    32'(count_a),  32'd0);
    check("arst_full",     32'(full_a),   32'd0);
    check("arst_out",      32'(out_a),    32'd0);
    check("arst_events",   32'(events_a), 32'd0);
    check("arst_events_s", 32'(events_b), 32'd0);
    @(negedge clk);
    #1 rst = 1'b1;
    thresh = CW'(5);
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 1'b1);
      check("refill_full", 32'(full_a), 32'(i == 8));
      check("refill_out",  32'(out_a),  32'(i == 8));
    end

    // Random traffic with alternating ones density
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int r;
      int pct;
      r   = int'($urandom_range(0, 199));
      pct = (((cyc / 300) % 2) == 0) ? 80 : 35;
      clear = (r < 3);
      if ($urandom_range(0, 15) == 0) thresh = CW'($urandom_range(0, 10));
      in_val = ($urandom_range(0, 9) < 7);
      in_bit = (int'($urandom_range(0, 99)) < pct);
      if (r == 199) begin
        #2 rst = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    clear = 1'b0;
    in_val = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
